// File: rtl/dcache_refill_ctrl_if.sv
// Memory-bus side of the dcache refill controller: a write-back burst channel
// and a refill read-burst channel.
interface dcache_refill_ctrl_if;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic        wr_addr_ack;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        wr_done;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_addr_ack;
    logic        rd_valid;
    logic [31:0] rd_data;

    modport master (
        output wr_req, wr_addr, wr_valid, wr_data, rd_req, rd_addr,
        input  wr_addr_ack, wr_ready, wr_done, rd_addr_ack, rd_valid, rd_data
    );

    modport slave (
        input  wr_req, wr_addr, wr_valid, wr_data, rd_req, rd_addr,
        output wr_addr_ack, wr_ready, wr_done, rd_addr_ack, rd_valid, rd_data
    );
endinterface

// File: rtl/dcache_refill_ctrl.sv
// Data-cache miss sequencer: stalls the pipeline, writes back a dirty victim
// line, refills the missing line from memory and updates the tag.
module dcache_refill_ctrl #(
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned INDEX_W    = 7,
    parameter int unsigned OFF_W      = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          req_valid,
    input  logic [31:0]                   req_addr,
    input  logic                          hit,
    input  logic                          victim_dirty,
    input  logic [32-INDEX_W-OFF_W-3:0]   victim_tag,
    input  logic [31:0]                   victim_rdata,
    output logic                          stallreq,
    output logic [OFF_W-1:0]              victim_idx,
    dcache_refill_ctrl_if.master          bus,
    output logic                          refill_we,
    output logic [OFF_W-1:0]              refill_idx,
    output logic [31:0]                   refill_wdata,
    output logic                          tag_we
);
    localparam int unsigned TAG_W  = 32 - INDEX_W - OFF_W - 2;
    localparam int unsigned LINE_W = 32 - OFF_W - 2;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WB_ADDR = 3'd1;
    localparam logic [2:0] WB_DATA = 3'd2;
    localparam logic [2:0] WB_RESP = 3'd3;
    localparam logic [2:0] RD_ADDR = 3'd4;
    localparam logic [2:0] RD_DATA = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;

    logic [2:0]        state;
    logic [OFF_W-1:0]  cnt;
    logic [LINE_W-1:0] line_q;
    logic [TAG_W-1:0]  vtag_q;
    logic              miss;
    logic              unused_bits;

    assign miss        = req_valid & ~hit & ~flush;
    // Byte/word offset of the missing address is irrelevant: whole lines move.
    assign unused_bits = ^req_addr[OFF_W+1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            line_q <= '0;
            vtag_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        line_q <= req_addr[31:OFF_W+2];
                        vtag_q <= victim_tag;
                        state  <= victim_dirty ? WB_ADDR : RD_ADDR;
                    end
                end
                WB_ADDR: begin
                    // An early wr_ready alongside the ack is not a data beat.
                    if (bus.wr_addr_ack) begin
                        cnt   <= '0;
                        state <= WB_DATA;
                    end
                end
                WB_DATA: begin
                    if (bus.wr_ready) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_BEAT) state <= WB_RESP;
                    end
                end
                WB_RESP: begin
                    if (bus.wr_done) state <= RD_ADDR;
                end
                RD_ADDR: begin
                    if (bus.rd_addr_ack) begin
                        cnt   <= '0;
                        state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (bus.rd_valid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_BEAT) state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        stallreq     = (state == IDLE) ? miss : 1'b1;
        victim_idx   = '0;
        refill_we    = 1'b0;
        refill_idx   = '0;
        refill_wdata = '0;
        tag_we       = (state == DONE);
        bus.wr_req   = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_req   = 1'b0;
        bus.rd_addr  = '0;
        case (state)
            WB_ADDR: begin
                bus.wr_req  = 1'b1;
                bus.wr_addr = {vtag_q, line_q[INDEX_W-1:0], {(OFF_W+2){1'b0}}};
            end
            WB_DATA: begin
                bus.wr_valid = 1'b1;
                bus.wr_data  = victim_rdata;
                victim_idx   = cnt;
            end
            RD_ADDR: begin
                bus.rd_req  = 1'b1;
                bus.rd_addr = {line_q, {(OFF_W+2){1'b0}}};
            end
            RD_DATA: begin
                if (bus.rd_valid) begin
                    refill_we    = 1'b1;
                    refill_idx   = cnt;
                    refill_wdata = bus.rd_data;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Directed bench for dcache_refill_ctrl: hit, clean/dirty misses, bus stalls,
// read gaps, flush handling and mid-burst reset, checked cycle by cycle.
module tb_dcache_refill_ctrl;
    logic        clk;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        hit;
    logic        victim_dirty;
    logic [19:0] victim_tag;
    logic [31:0] victim_rdata;
    logic        stallreq;
    logic [2:0]  victim_idx;
    logic        refill_we;
    logic [2:0]  refill_idx;
    logic [31:0] refill_wdata;
    logic        tag_we;

    int unsigned n_checks;
    int unsigned n_fail;

    dcache_refill_ctrl_if bus ();

    dcache_refill_ctrl #(
        .LINE_WORDS (8),
        .INDEX_W    (7),
        .OFF_W      (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .hit          (hit),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag),
        .victim_rdata (victim_rdata),
        .stallreq     (stallreq),
        .victim_idx   (victim_idx),
        .bus          (bus),
        .refill_we    (refill_we),
        .refill_idx   (refill_idx),
        .refill_wdata (refill_wdata),
        .tag_we       (tag_we)
    );

    // Victim data array model: each word encodes its own index.
    assign victim_rdata = 32'hA5A5_0000 | 32'(victim_idx);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        flush           = 1'b0;
        req_valid       = 1'b0;
        req_addr        = '0;
        hit             = 1'b0;
        victim_dirty    = 1'b0;
        victim_tag      = '0;
        bus.wr_addr_ack = 1'b0;
        bus.wr_ready    = 1'b0;
        bus.wr_done     = 1'b0;
        bus.rd_addr_ack = 1'b0;
        bus.rd_valid    = 1'b0;
        bus.rd_data     = '0;
    endtask

    // Clean miss with immediate address ack and back-to-back beats; fl raises
    // flush throughout the read burst, which must not disturb it.
    task automatic clean_miss(input string nm, input logic [31:0] addr,
                              input logic [31:0] exp_raddr, input logic fl);
        int unsigned stalls;
        stalls       = 0;
        req_valid    = 1'b1;
        hit          = 1'b0;
        req_addr     = addr;
        victim_dirty = 1'b0;
        #1;
        check({nm, "_detect_stall"}, 32'(stallreq), 32'd1);
        check({nm, "_detect_rdreq"}, 32'(bus.rd_req), 32'd0);
        stalls += 32'(stallreq);
        @(negedge clk);
        bus.rd_addr_ack = 1'b1;
        #1;
        check({nm, "_rd_req"}, 32'(bus.rd_req), 32'd1);
        check({nm, "_rd_addr"}, bus.rd_addr, exp_raddr);
        stalls += 32'(stallreq);
        @(negedge clk);
        bus.rd_addr_ack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            flush        = fl;
            bus.rd_valid = 1'b1;
            bus.rd_data  = 32'hD000_0000 + 32'(k);
            #1;
            check($sformatf("%s_we%0d", nm, k), 32'(refill_we), 32'd1);
            check($sformatf("%s_idx%0d", nm, k), 32'(refill_idx), 32'(k));
            check($sformatf("%s_wdata%0d", nm, k), refill_wdata, 32'hD000_0000 + 32'(k));
            check($sformatf("%s_tagwe%0d", nm, k), 32'(tag_we), 32'd0);
            stalls += 32'(stallreq);
            @(negedge clk);
        end
        bus.rd_valid = 1'b0;
        #1;
        check({nm, "_done_tagwe"}, 32'(tag_we), 32'd1);
        check({nm, "_done_we"}, 32'(refill_we), 32'd0);
        stalls += 32'(stallreq);
        @(negedge clk);
        flush = 1'b0;
        hit   = 1'b1;
        #1;
        check({nm, "_retry_stall"}, 32'(stallreq), 32'd0);
        check({nm, "_retry_tagwe"}, 32'(tag_we), 32'd0);
        stalls += 32'(stallreq);
        check({nm, "_stall_cycles"}, 32'(stalls), 32'd11);
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        int unsigned k;
        int unsigned held;
        logic ready;
        logic v;
        n_checks = 0;
        n_fail   = 0;
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_stall", 32'(stallreq), 32'd0);
        check("rst_wr_req", 32'(bus.wr_req), 32'd0);
        check("rst_rd_req", 32'(bus.rd_req), 32'd0);
        check("rst_rd_addr", bus.rd_addr, 32'd0);
        check("rst_tag_we", 32'(tag_we), 32'd0);
        check("rst_refill_we", 32'(refill_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Hit: no stall, no bus activity on this or the next cycle.
        req_valid = 1'b1;
        hit       = 1'b1;
        req_addr  = 32'h0000_1234;
        #1;
        check("hit_stall", 32'(stallreq), 32'd0);
        @(negedge clk);
        #1;
        check("hit_rd_req", 32'(bus.rd_req), 32'd0);
        check("hit_wr_req", 32'(bus.wr_req), 32'd0);
        @(negedge clk);
        clear_inputs();

        clean_miss("clean", 32'h0000_1234, 32'h0000_1220, 1'b0);

        // Flush in IDLE never starts a miss.
        req_valid    = 1'b1;
        hit          = 1'b0;
        flush        = 1'b1;
        victim_dirty = 1'b1;
        req_addr     = 32'h0000_4444;
        #1;
        check("flush_idle_stall", 32'(stallreq), 32'd0);
        @(negedge clk);
        #1;
        check("flush_idle_wr_req", 32'(bus.wr_req), 32'd0);
        check("flush_idle_rd_req", 32'(bus.rd_req), 32'd0);
        @(negedge clk);
        clear_inputs();

        // Dirty miss: index 0x11, victim tag 0x1ABCD.
        req_valid    = 1'b1;
        req_addr     = 32'h0000_5234;
        victim_dirty = 1'b1;
        victim_tag   = 20'h1ABCD;
        #1;
        check("dirty_detect_stall", 32'(stallreq), 32'd1);
        check("dirty_detect_wr_req", 32'(bus.wr_req), 32'd0);
        @(negedge clk);
        victim_dirty = 1'b0;
        victim_tag   = '0;
        #1;
        check("wb_addr_req", 32'(bus.wr_req), 32'd1);
        check("wb_addr", bus.wr_addr, 32'h1ABC_D220);
        check("wb_addr_stall", 32'(stallreq), 32'd1);
        @(negedge clk);
        bus.wr_addr_ack = 1'b1;
        bus.wr_ready    = 1'b1;
        #1;
        check("wb_addr_hold", 32'(bus.wr_req), 32'd1);
        check("wb_addr_no_beat", 32'(bus.wr_valid), 32'd0);
        @(negedge clk);
        bus.wr_addr_ack = 1'b0;
        k    = 0;
        held = 0;
        for (int c = 0; c < 10; c++) begin
            ready        = !(k == 3 && held < 2);
            bus.wr_ready = ready;
            bus.rd_valid = 1'b1;
            #1;
            check($sformatf("wb_valid_c%0d", c), 32'(bus.wr_valid), 32'd1);
            check($sformatf("wb_idx_c%0d", c), 32'(victim_idx), k);
            check($sformatf("wb_data_c%0d", c), bus.wr_data, 32'hA5A5_0000 | k);
            check($sformatf("wb_ignore_rd_c%0d", c), 32'(refill_we), 32'd0);
            if (ready) k++;
            else held++;
            @(negedge clk);
        end
        bus.wr_ready = 1'b0;
        bus.rd_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            check($sformatf("wb_resp_valid%0d", c), 32'(bus.wr_valid), 32'd0);
            check($sformatf("wb_resp_rd_req%0d", c), 32'(bus.rd_req), 32'd0);
            check($sformatf("wb_resp_stall%0d", c), 32'(stallreq), 32'd1);
            @(negedge clk);
        end
        bus.wr_done = 1'b1;
        #1;
        check("wb_done_rd_req", 32'(bus.rd_req), 32'd0);
        @(negedge clk);
        bus.wr_done = 1'b0;
        #1;
        check("dirty_rd_req", 32'(bus.rd_req), 32'd1);
        check("dirty_rd_addr", bus.rd_addr, 32'h0000_5220);
        @(negedge clk);
        bus.rd_addr_ack = 1'b1;
        #1;
        check("dirty_rd_hold", 32'(bus.rd_req), 32'd1);
        @(negedge clk);
        bus.rd_addr_ack = 1'b0;
        k = 0;
        for (int c = 0; c < 22; c++) begin
            v            = (c % 3 == 0);
            bus.rd_valid = v;
            bus.rd_data  = 32'hE000_0000 + k;
            #1;
            check($sformatf("gap_we_c%0d", c), 32'(refill_we), 32'(v));
            if (v) begin
                check($sformatf("gap_idx_c%0d", c), 32'(refill_idx), k);
                check($sformatf("gap_wdata_c%0d", c), refill_wdata, 32'hE000_0000 + k);
                k++;
            end
            check($sformatf("gap_tagwe_c%0d", c), 32'(tag_we), 32'd0);
            @(negedge clk);
        end
        bus.rd_valid = 1'b0;
        #1;
        check("dirty_done_tagwe", 32'(tag_we), 32'd1);
        check("dirty_done_stall", 32'(stallreq), 32'd1);
        @(negedge clk);
        hit = 1'b1;
        #1;
        check("dirty_retry_stall", 32'(stallreq), 32'd0);
        @(negedge clk);
        clear_inputs();

        clean_miss("flushrd", 32'h0001_0ABC, 32'h0001_0AA0, 1'b1);

        // Reset during write-back beat 4.
        req_valid    = 1'b1;
        req_addr     = 32'h0000_5234;
        victim_dirty = 1'b1;
        victim_tag   = 20'h0F00F;
        @(negedge clk);
        victim_dirty    = 1'b0;
        bus.wr_addr_ack = 1'b1;
        @(negedge clk);
        bus.wr_addr_ack = 1'b0;
        bus.wr_ready    = 1'b1;
        for (int c = 0; c < 4; c++) @(negedge clk);
        bus.wr_ready = 1'b0;
        #1;
        check("rstmid_beat4_idx", 32'(victim_idx), 32'd4);
        check("rstmid_beat4_valid", 32'(bus.wr_valid), 32'd1);
        rst       = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid_wr_valid", 32'(bus.wr_valid), 32'd0);
        check("rstmid_wr_req", 32'(bus.wr_req), 32'd0);
        check("rstmid_rd_req", 32'(bus.rd_req), 32'd0);
        check("rstmid_victim_idx", 32'(victim_idx), 32'd0);
        check("rstmid_stall", 32'(stallreq), 32'd0);
        @(negedge clk);
        clear_inputs();

        clean_miss("postrst", 32'h0000_0040, 32'h0000_0040, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
